// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and loader state type
package program_loader_pkg;

  localparam logic [1:0] ACCESS_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_HALF = 2'd1;
  localparam logic [1:0] ACCESS_WORD = 2'd2;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_address(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - control, byte stream and memory setup bus of the loader
interface program_loader_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 start;
  logic [31:0]          base_address;
  logic [LEN_WIDTH-1:0] length_words;
  logic                 in_valid;
  logic [7:0]           in_byte;
  logic                 in_ready;
  logic                 setup_write;
  logic [31:0]          setup_address;
  logic [31:0]          setup_data_in;
  logic                 core_reset;
  logic                 busy;
  logic                 done;

  modport master (
    output start, base_address, length_words, in_valid, in_byte,
    input  in_ready, setup_write, setup_address, setup_data_in, core_reset, busy, done
  );

  modport slave (
    input  start, base_address, length_words, in_valid, in_byte,
    output in_ready, setup_write, setup_address, setup_data_in, core_reset, busy, done
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - little-endian byte-to-word assembly
module word_assembler (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_complete
);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_word;

  // Word as it will look once the current byte is inserted; lets the
  // loader capture a full word on the same edge that takes byte 3.
  always_comb begin
    o_word_next = r_word;
    case (r_byte_cnt)
      2'd0:    o_word_next[7:0]   = i_byte;
      2'd1:    o_word_next[15:8]  = i_byte;
      2'd2:    o_word_next[23:16] = i_byte;
      default: o_word_next[31:24] = i_byte;
    endcase
  end

  assign o_word_complete = i_accept && (r_byte_cnt == 2'd3);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_byte_cnt <= 2'd0;
      r_word     <= 32'd0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_word     <= o_word_next;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams bytes into core memory words, then releases core reset
module program_loader
  import program_loader_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  program_loader_if.slave  bus
);

  loader_state_t        r_state;
  logic [31:0]          r_base;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_word_idx;
  logic                 r_setup_write;
  logic [31:0]          r_setup_address;
  logic [31:0]          r_setup_data;

  logic                 w_accept;
  logic                 w_start_ok;
  logic [31:0]          w_word_next;
  logic                 w_word_complete;
  logic [LEN_WIDTH-1:0] w_idx_next;

  assign w_accept   = bus.in_valid && (r_state == ST_COLLECT);
  assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_idx_next = r_word_idx + LEN_WIDTH'(1);

  word_assembler u_word_assembler (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_clear         (w_start_ok),
    .i_accept        (w_accept),
    .i_byte          (bus.in_byte),
    .o_word_next     (w_word_next),
    .o_word_complete (w_word_complete)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_base          <= 32'd0;
      r_len           <= '0;
      r_word_idx      <= '0;
      r_setup_write   <= 1'b0;
      r_setup_address <= 32'd0;
      r_setup_data    <= 32'd0;
    end else begin
      r_setup_write <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_base     <= bus.base_address;
            r_len      <= bus.length_words;
            r_word_idx <= '0;
            r_state    <= (bus.length_words == '0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // Strobe and payload are registered here so WRITE drives them directly.
          if (w_word_complete) begin
            r_state         <= ST_WRITE;
            r_setup_write   <= 1'b1;
            r_setup_address <= word_address(r_base, 32'(r_word_idx));
            r_setup_data    <= w_word_next;
          end
        end
        ST_WRITE: begin
          r_word_idx <= w_idx_next;
          r_state    <= (w_idx_next == r_len) ? ST_DONE : ST_COLLECT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (r_state == ST_COLLECT);
  assign bus.busy          = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
  assign bus.done          = (r_state == ST_DONE);
  assign bus.core_reset    = (r_state != ST_DONE);
  assign bus.setup_write   = r_setup_write;
  assign bus.setup_address = r_setup_address;
  assign bus.setup_data_in = r_setup_data;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  program_loader_if #(.LEN_WIDTH(16)) bus ();

  program_loader #(.LEN_WIDTH(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          writes      = 0;
  int          w0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.setup_write === 1'b1) begin
      writes++;
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("wr_addr", bus.setup_address, sb_e[63:32]);
        check("wr_data", bus.setup_data_in, sb_e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] len);
    bus.start        = 1'b1;
    bus.base_address = base;
    bus.length_words = len;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_word();
    check("wr_latency", 32'(bus.setup_write), 32'd1);
    tick();
    check("wr_one_cycle", 32'(bus.setup_write), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit gap);
    sb_q.push_back({addr, data});
    for (int k = 0; k < 4; k++) begin
      send_byte(data[8*k +: 8]);
      if (gap && k == 2) begin
        repeat (5) tick();
        check("gap_no_write", 32'(bus.setup_write), 32'd0);
        check("gap_busy", 32'(bus.busy), 32'd1);
      end
    end
    finish_word();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("done_reached", 32'(bus.done), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b1;
    bus.base_address = 32'h55;
    bus.length_words = 16'd3;
    bus.in_valid     = 1'b1;
    bus.in_byte      = 8'hAA;
    repeat (3) tick();
    check("rst_prio_busy", 32'(bus.busy), 32'd0);
    check("rst_prio_done", 32'(bus.done), 32'd0);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_core_reset", 32'(bus.core_reset), 32'd1);
    check("rst_setup_write", 32'(bus.setup_write), 32'd0);
    check("rst_setup_addr", bus.setup_address, 32'd0);
    check("rst_setup_data", bus.setup_data_in, 32'd0);

    do_start(32'h100, 16'd2);
    check("load_busy", 32'(bus.busy), 32'd1);
    check("load_core_reset", 32'(bus.core_reset), 32'd1);
    send_word(32'h100, 32'h00100513, 1'b0);
    send_word(32'h104, 32'h00200593, 1'b0);
    wait_done();
    check("done_core_reset", 32'(bus.core_reset), 32'd0);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    check("write_count", 32'(writes), 32'd2);

    do_start(32'h600, 16'd1);
    check("restart_core_reset", 32'(bus.core_reset), 32'd1);
    send_word(32'h600, 32'hCAFEF00D, 1'b0);
    wait_done();

    pulse_reset();
    w0 = writes;
    do_start(32'h700, 16'd0);
    check("len0_done", 32'(bus.done), 32'd1);
    check("len0_core_reset", 32'(bus.core_reset), 32'd0);
    check("len0_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    check("len0_no_write", 32'(writes - w0), 32'd0);

    do_start(32'h200, 16'd1);
    send_word(32'h200, 32'h12345678, 1'b1);
    wait_done();

    do_start(32'h500, 16'd2);
    sb_q.push_back({32'h500, 32'hA1B2C3D4});
    send_byte(8'hD4);
    send_byte(8'hC3);
    do_start(32'h900, 16'd5);
    send_byte(8'hB2);
    send_byte(8'hA1);
    finish_word();
    send_word(32'h504, 32'h0F1E2D3C, 1'b0);
    wait_done();

    do_start(32'h300, 16'd2);
    w0 = writes;
    send_word(32'h300, 32'h11223344, 1'b0);
    send_byte(8'h66);
    send_byte(8'h55);
    pulse_reset();
    tick();
    check("abort_writes", 32'(writes - w0), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_core_reset", 32'(bus.core_reset), 32'd1);
    check("abort_setup_addr", bus.setup_address, 32'd0);
    do_start(32'h400, 16'd1);
    send_word(32'h400, 32'hDEADBEEF, 1'b0);
    wait_done();

    do_start(32'hFFFFFFFC, 16'd2);
    send_word(32'hFFFFFFFC, 32'h87654321, 1'b0);
    send_word(32'h00000000, 32'h0BADF00D, 1'b0);
    wait_done();

    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
